// File: rtl/prod_accumulator_if.sv
// Product-stream / result-stream bundle between the multiplier feeder,
// the product accumulator and the downstream result consumer.
interface prod_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  logic              out_forced;

  // Accumulator side: sinks products, sources results
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf, out_forced
  );

  // Environment side: sources products, sinks results
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf, out_forced
  );
endinterface

// File: rtl/prod_accumulator.sv
// Saturating product accumulator: sums a run of unsigned products from the
// Dadda multiplier and presents total, term count and overflow/forced flags.
module prod_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  prod_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_TERMS);
  localparam bit               ONE_TERM = (MAX_TERMS == 1);

  // Returns {overflow, saturated_sum}; the add is one bit wider than the
  // accumulator so the carry-out flags the overflow.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    if (s[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             forced_q, forced_d;

  logic [ACC_W-1:0] sum_o_q;
  logic [CNT_W-1:0] count_o_q;
  logic             ovf_o_q;
  logic             forced_o_q;

  logic             ready_w;
  logic             xfer_w;
  logic             load_out_w;
  logic [ACC_W:0]   add_w;
  logic [CNT_W-1:0] cnt_inc_w;

  // Ready is a decode of the registered state, gated low while in reset.
  assign ready_w       = (state_q != HOLD);
  assign xfer_w        = bus.in_valid & ready_w;
  assign add_w         = sat_add(acc_q, bus.in_prod);
  assign cnt_inc_w     = cnt_q + CNT_W'(1);
  assign load_out_w    = (state_q != HOLD) && (state_d == HOLD);

  assign bus.in_ready   = rst_n & ready_w;
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_sum    = sum_o_q;
  assign bus.out_count  = count_o_q;
  assign bus.out_ovf    = ovf_o_q;
  assign bus.out_forced = forced_o_q;

  // Next-state and run-accumulator update for the IDLE/ACCUM/HOLD controller
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    forced_d = forced_q;
    unique case (state_q)
      IDLE: begin
        if (xfer_w) begin
          acc_d    = ACC_W'(bus.in_prod);
          cnt_d    = CNT_W'(1);
          ovf_d    = 1'b0;
          forced_d = ONE_TERM && !bus.in_last;
          state_d  = (bus.in_last || ONE_TERM) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer_w) begin
          acc_d = add_w[ACC_W-1:0];
          ovf_d = ovf_q | add_w[ACC_W];
          cnt_d = cnt_inc_w;
          if (bus.in_last) begin
            forced_d = 1'b0;
            state_d  = HOLD;
          end else if (cnt_inc_w == MAX_CNT) begin
            forced_d = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state and running total of the open run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      forced_q <= forced_d;
    end
  end

  // Result registers: captured on the closing transfer, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_o_q    <= '0;
      count_o_q  <= '0;
      ovf_o_q    <= 1'b0;
      forced_o_q <= 1'b0;
    end else if (load_out_w) begin
      sum_o_q    <= acc_d;
      count_o_q  <= cnt_d;
      ovf_o_q    <= ovf_d;
      forced_o_q <= forced_d;
    end
  end

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Sequential stage directly downstream of the team's 4x4 combinational Dadda multiplier.
- Consumes the 8-bit product stream over a valid/ready handshake.
- Sums a variable-length run of products (a dot product) into a wider saturating accumulator.
- Presents the run total, term count and overflow flag on a valid/ready output port. This turns the multiplier into a MAC datapath.

Parameters:
PROD_W, 8, width of incoming product (matches multiplier p[8:1])
ACC_W, 16, accumulator/result width; must be >= PROD_W
MAX_TERMS, 16, maximum products per run; the run force-closes on reaching it
CNT_W, 5, term counter width; must hold MAX_TERMS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  product present on in_prod
in_ready  output  1  block can accept a product this cycle
in_prod  input  PROD_W  unsigned product from multiplier
in_last  input  1  accompanies the final product of a run
out_valid  output  1  result held on out_sum/out_count/out_ovf
out_ready  input  1  downstream accepts result
out_sum  output  ACC_W  saturated run total
out_count  output  CNT_W  number of products accepted in the run
out_ovf  output  1  sticky: run total exceeded 2^ACC_W-1
out_forced  output  1  run closed by MAX_TERMS, not by in_last

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, acc=0, cnt=0, ovf=0, forced=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, out_forced=0.
  - in_ready=0 while rst_n low.
- States: IDLE (no run open), ACCUM (run open), HOLD (result presented).
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. It is a registered-state decode, not combinational from out_ready.
- Transfer in = in_valid & in_ready at the clock edge. No transfer means no state change.
- IDLE + transfer:
  - acc=in_prod, cnt=1, ovf=0.
  - If in_last, or MAX_TERMS==1, go to HOLD. Otherwise go to ACCUM.
- ACCUM + transfer:
  - sum = acc + in_prod, computed ACC_W+1 bits wide.
  - If sum > 2^ACC_W-1: acc=all ones, ovf=1. Otherwise acc=sum.
  - Once saturated, acc stays all ones; ovf stays 1 until a new run starts.
  - cnt += 1.
  - If in_last: go to HOLD.
  - Else if cnt+1 == MAX_TERMS: go to HOLD with forced=1.
  - Else stay in ACCUM.
- Entering HOLD: out_valid=1 on the cycle after the closing transfer (latency 1). out_sum/out_count/out_ovf/out_forced are registered and stable while out_valid=1.
- HOLD & out_ready: out_valid=0 next cycle and state goes to IDLE. in_ready rises that same next cycle, so there is no same-cycle output-accept/input-accept overlap; throughput is 1 product/cycle within a run plus 1 bubble per run.
- HOLD & !out_ready: hold all outputs and keep in_ready=0 (backpressure to the multiplier feeder).
- in_last with in_valid=0 is ignored. in_prod/in_last are don't-care when in_valid=0.
- Outputs other than out_valid keep their last values after handshake until the next HOLD entry.
- rst_n low mid-run or in HOLD: the partial run is discarded immediately and all outputs go to reset values.
- Arithmetic is unsigned only. in_prod is zero-extended to ACC_W.

Test Plan:
- Single-term run: in_prod=225, in_last=1 from IDLE -> next cycle out_valid=1, out_sum=225, out_count=1, out_ovf=0, out_forced=0.
- Back-to-back run of products 6,12,20,30, with last on 30 and out_ready=1 -> out_sum=68, out_count=4. in_ready=0 for exactly one cycle (HOLD), then 1.
- Saturation (ACC_W=10): five products of 225 with last -> out_sum=1023, out_ovf=1, out_count=5. The next run of a single 9 -> out_sum=9, out_ovf=0.
- Forced close (MAX_TERMS=4): 6 products of 1, no in_last:
  - First result: out_sum=4, out_count=4, out_forced=1.
  - Remaining 2 products form a new run that stays in ACCUM until in_last arrives.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0 throughout, outputs stable, no product consumed. On out_ready=1, the pending product is accepted the cycle after out_valid falls.
- Async reset: assert rst_n low in ACCUM after 3 terms (between clock edges) -> outputs zero immediately. After release, a single run of 7 with last -> out_sum=7, out_count=1.
